// File: rtl/fifo_burst_reader.sv
// Burst consumer for a synchronous FIFO: pops burst_len words and re-presents them on a
// valid/ready stream through an output register backed by a 2-entry skid buffer.
module fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int ADDR  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADDR:0]    burst_len,
    output logic             busy,
    output logic             done,
    output logic             fifo_read,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] CNT_ONE = (ADDR+1)'(1);

    state_t           state_q, state_d;
    logic [ADDR:0]    issue_cnt_q, issue_cnt_d;
    logic [ADDR:0]    xfer_cnt_q, xfer_cnt_d;
    logic             rd_inflight_q;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid0_q, skid0_d;
    logic [WIDTH-1:0] skid1_q, skid1_d;
    logic [1:0]       skid_cnt_q, skid_cnt_d;

    logic [ADDR:0]    len_clamped;
    logic [1:0]       credit_used;
    logic             pop;
    logic [1:0]       occ;
    logic [WIDTH-1:0] e0, e1, e2;

    assign len_clamped = (burst_len > DEPTH_C) ? DEPTH_C : burst_len;
    assign pop         = out_vld_q && m_ready;

    // The output register is not counted as credit, so a word can be requested every
    // cycle while the stream drains; the skid entries absorb the data still in flight.
    assign credit_used = skid_cnt_q + {1'b0, rd_inflight_q};
    assign fifo_read   = (state_q == S_RUN) && (issue_cnt_q != '0) && !fifo_empty
                         && (credit_used < 2'd2);

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign m_valid = out_vld_q;
    assign m_data  = out_data_q;
    assign m_last  = out_vld_q && (xfer_cnt_q == CNT_ONE);

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    issue_cnt_d = len_clamped;
                    xfer_cnt_d  = len_clamped;
                    state_d     = (len_clamped == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (fifo_read) begin
                    issue_cnt_d = issue_cnt_q - CNT_ONE;
                end
                if (pop && (xfer_cnt_q != '0)) begin
                    xfer_cnt_d = xfer_cnt_q - CNT_ONE;
                end
                if (pop && (xfer_cnt_q == CNT_ONE)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register plus skid entries behave as one 3-deep queue: pop the head, then
    // append the returning FIFO word behind whatever remains, preserving order.
    always_comb begin
        e0  = out_data_q;
        e1  = skid0_q;
        e2  = skid1_q;
        occ = {1'b0, out_vld_q} + skid_cnt_q;
        if (pop) begin
            e0  = e1;
            e1  = e2;
            occ = occ - 2'd1;
        end
        if (rd_inflight_q) begin
            case (occ)
                2'd0:    e0 = fifo_data;
                2'd1:    e1 = fifo_data;
                2'd2:    e2 = fifo_data;
                default: e2 = e2;
            endcase
            if (occ != 2'd3) begin
                occ = occ + 2'd1;
            end
        end
        out_vld_d  = (occ != 2'd0);
        out_data_d = e0;
        skid0_d    = e1;
        skid1_d    = e2;
        skid_cnt_d = (occ == 2'd0) ? 2'd0 : occ - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            issue_cnt_q   <= '0;
            xfer_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
            out_vld_q     <= 1'b0;
            out_data_q    <= '0;
            skid0_q       <= '0;
            skid1_q       <= '0;
            skid_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            xfer_cnt_q    <= xfer_cnt_d;
            rd_inflight_q <= fifo_read;
            out_vld_q     <= out_vld_d;
            out_data_q    <= out_data_d;
            skid0_q       <= skid0_d;
            skid1_q       <= skid1_d;
            skid_cnt_q    <= skid_cnt_d;
        end
    end

endmodule
